// File: rtl/equiv_miter_monitor_if.sv
// Bus between the equivalence harness and the miter monitor: the two
// implementation outputs with their control strobes going in, and the
// verdict/capture signals coming back out.
interface equiv_miter_monitor_if #(
    parameter int WIDTH = 91,
    parameter int CNT_W = 16
);
    logic             en;
    logic             clear;
    logic [WIDTH-1:0] y_a;
    logic [WIDTH-1:0] y_b;
    logic             checking;
    logic             mismatch;
    logic             fail;
    logic [CNT_W-1:0] mismatch_count;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] first_fail_cycle;
    logic [WIDTH-1:0] first_diff;

    // Harness side: drives the samples, observes the verdict
    modport master (
        output en, clear, y_a, y_b,
        input  checking, mismatch, fail, mismatch_count, cycle_count,
               first_fail_cycle, first_diff
    );

    // Monitor side: consumes the samples, reports the verdict
    modport slave (
        input  en, clear, y_a, y_b,
        output checking, mismatch, fail, mismatch_count, cycle_count,
               first_fail_cycle, first_diff
    );
endinterface

// File: rtl/equiv_miter_monitor.sv
// Cycle-by-cycle equivalence monitor for two implementations of one design.
// Each side is delayed by its own alignment line so the samples line up, a
// warm-up window is masked, and the first failing sample is captured.
module equiv_miter_monitor #(
    parameter int WIDTH        = 91,
    parameter int LAT_A        = 0,
    parameter int LAT_B        = 0,
    parameter int WARMUP       = 2,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    equiv_miter_monitor_if.slave bus
);
    localparam int MAX_LAT  = (LAT_A > LAT_B) ? LAT_A : LAT_B;
    localparam int MASK_LEN = WARMUP + MAX_LAT;
    localparam int MASK_W   = $clog2(MASK_LEN + 2);
    localparam logic [MASK_W-1:0] MASK_LAST = MASK_W'(MASK_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_CHECK,
        ST_HALTED
    } state_t;

    state_t             state;
    logic [MASK_W-1:0]  mask_cnt;
    logic               mismatch_r;
    logic               fail_r;
    logic [CNT_W-1:0]   mismatch_cnt;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   first_cycle_r;
    logic [WIDTH-1:0]   first_diff_r;

    logic               restart;
    logic [WIDTH-1:0]   a_al;
    logic [WIDTH-1:0]   b_al;
    logic               do_compare;
    logic               fire;

    // Reset and clear are the same soft restart of every register
    assign restart = !rst_n || bus.clear;

    generate
        if (LAT_A == 0) begin : g_a_pass
            assign a_al = bus.y_a;
        end else begin : g_a_dly
            logic [WIDTH-1:0] line [LAT_A];

            // Shift side-A samples one stage per enabled cycle
            always_ff @(posedge clk) begin
                if (restart) begin
                    for (int i = 0; i < LAT_A; i++) line[i] <= '0;
                end else if (bus.en) begin
                    line[0] <= bus.y_a;
                    for (int i = 1; i < LAT_A; i++) line[i] <= line[i-1];
                end
            end

            assign a_al = line[LAT_A-1];
        end

        if (LAT_B == 0) begin : g_b_pass
            assign b_al = bus.y_b;
        end else begin : g_b_dly
            logic [WIDTH-1:0] line [LAT_B];

            // Shift side-B samples one stage per enabled cycle
            always_ff @(posedge clk) begin
                if (restart) begin
                    for (int i = 0; i < LAT_B; i++) line[i] <= '0;
                end else if (bus.en) begin
                    line[0] <= bus.y_b;
                    for (int i = 1; i < LAT_B; i++) line[i] <= line[i-1];
                end
            end

            assign b_al = line[LAT_B-1];
        end
    endgenerate

    // With no masked window the very first enabled sample is already judged;
    // case inequality makes X/Z bits count as a difference in simulation
    assign do_compare = bus.en &&
                        ((state == ST_CHECK) || ((state == ST_IDLE) && (MASK_LEN == 0)));
    assign fire       = do_compare && (a_al !== b_al);

    // Warm-up/check sequencing, counters, mismatch pulse and first-fail capture
    always_ff @(posedge clk) begin
        if (restart) begin
            state         <= ST_IDLE;
            mask_cnt      <= '0;
            mismatch_r    <= 1'b0;
            fail_r        <= 1'b0;
            mismatch_cnt  <= '0;
            cycle_cnt     <= '0;
            first_cycle_r <= '0;
            first_diff_r  <= '0;
        end else begin
            mismatch_r <= 1'b0;
            if (bus.en) begin
                if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;

                case (state)
                    ST_IDLE: begin
                        if (MASK_LEN == 0) begin
                            state <= (fire && (STOP_ON_FAIL != 0)) ? ST_HALTED : ST_CHECK;
                        end else if (MASK_LEN == 1) begin
                            state <= ST_CHECK;
                        end else begin
                            state    <= ST_WARMUP;
                            mask_cnt <= MASK_W'(1);
                        end
                    end
                    ST_WARMUP: begin
                        mask_cnt <= mask_cnt + 1'b1;
                        if (mask_cnt == MASK_LAST) state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (fire && (STOP_ON_FAIL != 0)) state <= ST_HALTED;
                    end
                    default: begin
                        state <= ST_HALTED;
                    end
                endcase

                if (fire) begin
                    mismatch_r <= 1'b1;
                    if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (!fail_r) begin
                        fail_r        <= 1'b1;
                        first_cycle_r <= cycle_cnt;
                        first_diff_r  <= a_al ^ b_al;
                    end
                end
            end
        end
    end

    assign bus.checking         = (state == ST_CHECK);
    assign bus.mismatch         = mismatch_r;
    assign bus.fail             = fail_r;
    assign bus.mismatch_count   = mismatch_cnt;
    assign bus.cycle_count      = cycle_cnt;
    assign bus.first_fail_cycle = first_cycle_r;
    assign bus.first_diff       = first_diff_r;
endmodule
